hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Consumer side of the decode stage's register-use/produce contract. Takes the decoded GRF read
//  addrs/use-stages and write addr/ready-stage, tracks in-flight writers in the DE/EM/MW registers,
//  and drives the pipeline stall plus the operand-forwarding selects for the D, E and M stages.
// PARAMETERS
//  none (all encodings come from def.v)
// PORTS
//  clk             in   1  clock; all state updates on posedge
//  reset           in   1  synchronous, active-high
//  d_read_addr0    in   5  rs of the instr in D
//  d_read_addr1    in   5  rt of the instr in D
//  d_read_stage0   in   2  use stage U0 of rs (STAGE_*); STAGE_MAX = not read
//  d_read_stage1   in   2  use stage U1 of rt (STAGE_*); STAGE_MAX = not read
//  d_write_addr    in   5  dest reg of the instr in D; 0 = no write
//  d_write_stage   in   2  stage T that produces the result (DECODE/EXECUTE/MEM)
//  stall           out  1  hold PC and IF/ID; inject a bubble into DE
//  fwd_d0, fwd_d1  out  2  D-stage operand source (FWD_GRF/DE/EM/MW)
//  fwd_e0, fwd_e1  out  2  E-stage operand source (FWD_GRF/EM/MW)
//  fwd_m1          out  2  M-stage store-data source (FWD_GRF/MW)
// BEHAVIOUR
//  - Encodings: STAGE_DECODE=0, EXECUTE=1, MEM=2, MAX=3. FWD_GRF=0, DE=1, EM=2, MW=3.
//    Register index P: DE=1, EM=2, MW=3.
//  - Each register P holds {waddr[4:0], tnew[1:0], raddr0, raddr1}.
//    tnew = cycles until the value sits in a pipeline register.
//    On D->DE entry: tnew = sat0(T + 1 - 1) = T; waddr = d_write_addr.
//    Every advance: tnew = sat0(tnew - 1).
//  - Posedge, no stall: DE<=D info, EM<=DE, MW<=EM.
//    Posedge, stall: DE<=bubble (all zero), EM<=DE, MW<=EM.
//    reset: all entries zero for that cycle, overriding stall.
//  - stall (combinational): for k in {0,1}, d_read_addr_k!=0, d_read_stage_k!=MAX, and the NEWEST
//    register P whose waddr==d_read_addr_k has tnew > U_k. Older matches are ignored.
//  - fwd selects (combinational): consumer in stage C looks at registers P > C only.
//    Take the newest P with waddr==addr!=0.
//      tnew==0 -> select FWD for P.
//      tnew>0  -> FWD_GRF (no fall-through to older stale producers).
//      no match -> FWD_GRF.
//  - Addr 0 never stalls and never forwards.
//  - Latency 0 for stall/fwd; state latency 1 cycle.
//  - Reset values: stall=0, all fwd_*=FWD_GRF (entries zero).
//  - Simultaneous rs/rt hazards: single stall. A stall repeats each cycle until the condition
//    clears; no livelock, because tnew strictly decreases.
//  - Reset asserted mid-stall: next cycle stall=0, pipeline state empty.
// CONFIGURATION
//  HAZARD_PERF_EN
//    defined: adds output stall_count (32 bits). Cleared by reset, +1 on each clk where
//      stall=1, wraps at 2^32.
//    undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - def.v gains the FWD_* constants. STAGE_* encodings stay in def.v.
//  - Sub-module hazard_fwd_pick: combinational newest-match priority picker
//    (inputs: addr, three entries, min P); instantiated 5x (d0,d1,e0,e1,m1).
//  - The pipeline-tracking registers live in hazard_ctrl.
// TESTING
//  1. reset=1 for 2 cycles with random inputs -> stall=0, all fwd=0 during and on the cycle after.
//  2. lw $8 (T=2) then add $9,$8,$8 (U=1)
//     -> stall=1 for exactly 1 cycle; next cycle fwd_e0=fwd_e1=FWD_MW.
//  3. lw $8 then beq $8,$0 (U0=0) -> stall 2 cycles, then fwd_d0=FWD_MW.
//     addu $8 then beq $8 -> stall 1 cycle, then fwd_d0=FWD_EM.
//  4. jal (waddr=31, T=0) then jr $31 -> no stall, fwd_d0=FWD_DE.
//  5. lw $8 then sw $8,0($9) (U1=2) -> no stall; the sw in E gets fwd_e1=FWD_GRF;
//     the sw in M gets fwd_m1=FWD_MW.
//  6. ori $5 then addu $5 then add $6,$5,$0
//     -> fwd_e0=FWD_EM (newest match wins, not MW); reads of $0 always FWD_GRF, never stall.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared encodings, pipeline entry type and newest-match picker for hazard_ctrl
package hazard_ctrl_pkg;
  localparam logic [1:0] STAGE_MAX = 2'd3;
  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_DE = 2'd1;
  localparam logic [1:0] FWD_EM = 2'd2;
  localparam logic [1:0] FWD_MW = 2'd3;
  typedef struct packed {
    logic [4:0] waddr;
    logic [1:0] tnew;
  } ent_t;
  typedef struct packed {
    logic hit;
    logic [1:0] p;
    logic [1:0] tnew;
  } pick_t;
  // Walks oldest to newest so the newest match (lowest P) wins; only P > min_p is considered.
  function automatic pick_t pick(input logic [4:0] addr, input ent_t [2:0] ent, input logic [1:0] min_p);
    pick_t r;
    r = '0;
    for (int i = 2; i >= 0; i--)
      if (addr != 5'd0 && 2'(i + 1) > min_p && ent[i].waddr == addr)
        r = '{hit: 1'b1, p: 2'(i + 1), tnew: ent[i].tnew};
    return r;
  endfunction
  function automatic logic [1:0] dec(input logic [1:0] t);
    return t == 2'd0 ? 2'd0 : t - 2'd1;
  endfunction
endpackage

// File: rtl/hazard_fwd_pick.sv
// hazard_fwd_pick: forwarding select for one consumer operand
//   addr_i  : register read by the consumer
//   ent_i   : DE/EM/MW entries (index 0 = DE)
//   min_p_i : consumer stage; only entries with P > min_p_i are eligible
//   fwd_o   : FWD_* select
import hazard_ctrl_pkg::*;
module hazard_fwd_pick (
  input  logic [4:0] addr_i,
  input  ent_t [2:0] ent_i,
  input  logic [1:0] min_p_i,
  output logic [1:0] fwd_o
);
  pick_t r;
  assign r = pick(addr_i, ent_i, min_p_i);
  // a newest producer that is not ready yet blocks older stale matches
  assign fwd_o = (!r.hit || r.tnew != 2'd0) ? FWD_GRF :
                 r.p == 2'd1 ? FWD_DE : r.p == 2'd2 ? FWD_EM : FWD_MW;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: tracks in-flight writers in DE/EM/MW, drives stall and D/E/M forwarding selects
//   clk, reset (sync, active-high)
//   d_read_addr0/1, d_read_stage0/1 : operands and use stages of the instr in D
//   d_write_addr, d_write_stage     : destination and producing stage of the instr in D
//   stall                           : hold PC and IF/ID, bubble into DE
//   fwd_d0/d1, fwd_e0/e1, fwd_m1    : operand source selects
//   stall_count                     : present only when HAZARD_PERF_EN is defined
import hazard_ctrl_pkg::*;
module hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_read_addr0,
  input  logic [4:0] d_read_addr1,
  input  logic [1:0] d_read_stage0,
  input  logic [1:0] d_read_stage1,
  input  logic [4:0] d_write_addr,
  input  logic [1:0] d_write_stage,
  output logic       stall,
  output logic [1:0] fwd_d0,
  output logic [1:0] fwd_d1,
  output logic [1:0] fwd_e0,
  output logic [1:0] fwd_e1,
  output logic [1:0] fwd_m1
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_count
`endif
);
  ent_t [2:0] ent_q, ent_d;
  logic [4:0] de_r0_q, de_r1_q, em_r1_q;
  logic [4:0] de_r0_d, de_r1_d, em_r1_d;
  pick_t s0, s1;
  assign s0 = pick(d_read_addr0, ent_q, 2'd0);
  assign s1 = pick(d_read_addr1, ent_q, 2'd0);
  // only the newest writer of a register decides; older matches are already superseded
  assign stall = (d_read_stage0 != STAGE_MAX && s0.hit && s0.tnew > d_read_stage0) ||
                 (d_read_stage1 != STAGE_MAX && s1.hit && s1.tnew > d_read_stage1);
  always_comb begin
    ent_d[0] = stall ? '0 : '{waddr: d_write_addr, tnew: d_write_stage};
    ent_d[1] = '{waddr: ent_q[0].waddr, tnew: dec(ent_q[0].tnew)};
    ent_d[2] = '{waddr: ent_q[1].waddr, tnew: dec(ent_q[1].tnew)};
    de_r0_d = stall ? 5'd0 : d_read_addr0;
    de_r1_d = stall ? 5'd0 : d_read_addr1;
    em_r1_d = de_r1_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q <= '0;
      de_r0_q <= '0;
      de_r1_q <= '0;
      em_r1_q <= '0;
    end else begin
      ent_q <= ent_d;
      de_r0_q <= de_r0_d;
      de_r1_q <= de_r1_d;
      em_r1_q <= em_r1_d;
    end
  end
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count_q, stall_count_d;
  assign stall_count_d = stall_count_q + {31'd0, stall};
  always_ff @(posedge clk) stall_count_q <= reset ? 32'd0 : stall_count_d;
  assign stall_count = stall_count_q;
`endif
  hazard_fwd_pick u_d0 (.addr_i(d_read_addr0), .ent_i(ent_q), .min_p_i(2'd0), .fwd_o(fwd_d0));
  hazard_fwd_pick u_d1 (.addr_i(d_read_addr1), .ent_i(ent_q), .min_p_i(2'd0), .fwd_o(fwd_d1));
  hazard_fwd_pick u_e0 (.addr_i(de_r0_q), .ent_i(ent_q), .min_p_i(2'd1), .fwd_o(fwd_e0));
  hazard_fwd_pick u_e1 (.addr_i(de_r1_q), .ent_i(ent_q), .min_p_i(2'd1), .fwd_o(fwd_e1));
  hazard_fwd_pick u_m1 (.addr_i(em_r1_q), .ent_i(ent_q), .min_p_i(2'd2), .fwd_o(fwd_m1));
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench with an age-based pipeline model checked every cycle
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] d_read_addr0 = '0, d_read_addr1 = '0, d_write_addr = '0;
  logic [1:0] d_read_stage0 = 2'd3, d_read_stage1 = 2'd3, d_write_stage = '0;
  logic stall;
  logic [1:0] fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count;
  int mcount = 0;
`endif
  int errors = 0, checks = 0;
  bit en = 1'b0;
  always #5 clk = ~clk;
  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .d_read_addr0(d_read_addr0), .d_read_addr1(d_read_addr1),
    .d_read_stage0(d_read_stage0), .d_read_stage1(d_read_stage1),
    .d_write_addr(d_write_addr), .d_write_stage(d_write_stage),
    .stall(stall), .fwd_d0(fwd_d0), .fwd_d1(fwd_d1),
    .fwd_e0(fwd_e0), .fwd_e1(fwd_e1), .fwd_m1(fwd_m1)
`ifdef HAZARD_PERF_EN
    , .stall_count(stall_count)
`endif
  );
  // model: m[a] is the instruction that left D a cycles ago (1=DE, 2=EM, 3=MW)
  typedef struct { int wa; int t; int r0; int r1; } ins_t;
  ins_t m [1:3];
  initial for (int a = 1; a <= 3; a++) m[a] = '{0, 0, 0, 0};
  function automatic int rdy(int a);
    return m[a].t > a - 1 ? m[a].t - (a - 1) : 0;
  endfunction
  function automatic int newest(int addr, int c);
    for (int a = c + 1; a <= 3; a++) if (addr != 0 && m[a].wa == addr) return a;
    return 0;
  endfunction
  function automatic bit hz(int addr, int u);
    int a;
    a = newest(addr, 0);
    return addr != 0 && u != 3 && a != 0 && rdy(a) > u;
  endfunction
  function automatic int mfwd(int addr, int c);
    int a;
    a = newest(addr, c);
    return (a != 0 && rdy(a) == 0) ? a : 0;
  endfunction
  function automatic bit mstall();
    return hz(int'(d_read_addr0), int'(d_read_stage0)) || hz(int'(d_read_addr1), int'(d_read_stage1));
  endfunction
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", n, got, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    bit s;
    s = mstall();
    if (reset) for (int a = 1; a <= 3; a++) m[a] <= '{0, 0, 0, 0};
    else begin
      m[3] <= m[2];
      m[2] <= m[1];
      m[1] <= s ? '{0, 0, 0, 0} : '{int'(d_write_addr), int'(d_write_stage), int'(d_read_addr0), int'(d_read_addr1)};
    end
`ifdef HAZARD_PERF_EN
    mcount <= reset ? 0 : mcount + int'(s);
`endif
  end
  always @(negedge clk) if (en) begin
    chk("m_stall", {31'd0, stall}, {31'd0, mstall()});
    chk("m_fwd_d0", {30'd0, fwd_d0}, mfwd(int'(d_read_addr0), 0));
    chk("m_fwd_d1", {30'd0, fwd_d1}, mfwd(int'(d_read_addr1), 0));
    chk("m_fwd_e0", {30'd0, fwd_e0}, mfwd(m[1].r0, 1));
    chk("m_fwd_e1", {30'd0, fwd_e1}, mfwd(m[1].r1, 1));
    chk("m_fwd_m1", {30'd0, fwd_m1}, mfwd(m[2].r1, 2));
`ifdef HAZARD_PERF_EN
    chk("m_stall_count", stall_count, mcount);
`endif
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic setd(input int a0, input int u0, input int a1, input int u1, input int wa, input int t);
    d_read_addr0 = 5'(a0);
    d_read_stage0 = 2'(u0);
    d_read_addr1 = 5'(a1);
    d_read_stage1 = 2'(u1);
    d_write_addr = 5'(wa);
    d_write_stage = 2'(t);
  endtask
  task automatic flush();
    setd(0, 3, 0, 3, 0, 0);
    repeat (3) cyc();
  endtask
  task automatic chk_all_zero(input string n);
    @(negedge clk);
    chk(n, {21'd0, stall, fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1}, 32'd0);
  endtask
  initial begin
    cyc();
    en = 1'b1;
    repeat (2) begin
      setd($urandom_range(31), $urandom_range(3), $urandom_range(31), $urandom_range(3), $urandom_range(31), $urandom_range(3));
      chk_all_zero("reset_outputs");
      cyc();
    end
    reset = 1'b0;
    chk_all_zero("after_reset_outputs");
    flush();
    // lw $8 then add $9,$8,$8
    setd(0, 1, 0, 3, 8, 2); cyc();
    setd(8, 1, 8, 1, 9, 1);
    @(negedge clk); chk("lw_add_stall", {31'd0, stall}, 1);
    cyc();
    @(negedge clk); chk("lw_add_stall_clear", {31'd0, stall}, 0);
    cyc(); setd(0, 3, 0, 3, 0, 0);
    @(negedge clk); chk("lw_add_fwd_e0", {30'd0, fwd_e0}, 3); chk("lw_add_fwd_e1", {30'd0, fwd_e1}, 3);
    flush();
    // lw $8 then beq $8,$0
    setd(0, 1, 0, 3, 8, 2); cyc();
    setd(8, 0, 0, 0, 0, 0);
    @(negedge clk); chk("lw_beq_stall1", {31'd0, stall}, 1);
    cyc();
    @(negedge clk); chk("lw_beq_stall2", {31'd0, stall}, 1);
    cyc();
    @(negedge clk); chk("lw_beq_go", {31'd0, stall}, 0); chk("lw_beq_fwd_d0", {30'd0, fwd_d0}, 3);
    cyc(); flush();
    // addu $8 then beq $8
    setd(0, 1, 0, 1, 8, 1); cyc();
    setd(8, 0, 0, 0, 0, 0);
    @(negedge clk); chk("addu_beq_stall", {31'd0, stall}, 1);
    cyc();
    @(negedge clk); chk("addu_beq_go", {31'd0, stall}, 0); chk("addu_beq_fwd_d0", {30'd0, fwd_d0}, 2);
    cyc(); flush();
    // jal then jr $31
    setd(0, 3, 0, 3, 31, 0); cyc();
    setd(31, 0, 0, 3, 0, 0);
    @(negedge clk); chk("jal_jr_stall", {31'd0, stall}, 0); chk("jal_jr_fwd_d0", {30'd0, fwd_d0}, 1);
    cyc(); flush();
    // lw $8 then sw $8,0($9)
    setd(0, 1, 0, 3, 8, 2); cyc();
    setd(9, 1, 8, 2, 0, 0);
    @(negedge clk); chk("lw_sw_stall", {31'd0, stall}, 0);
    cyc(); setd(0, 3, 0, 3, 0, 0);
    @(negedge clk); chk("lw_sw_fwd_e1", {30'd0, fwd_e1}, 0);
    cyc();
    @(negedge clk); chk("lw_sw_fwd_m1", {30'd0, fwd_m1}, 3);
    flush();
    // ori $5; addu $5; add $6,$5,$0
    setd(0, 1, 0, 3, 5, 1); cyc();
    setd(0, 1, 0, 1, 5, 1); cyc();
    setd(5, 1, 0, 1, 6, 1);
    @(negedge clk); chk("newest_stall", {31'd0, stall}, 0); chk("zero_fwd_d1", {30'd0, fwd_d1}, 0);
    cyc(); setd(0, 3, 0, 3, 0, 0);
    @(negedge clk); chk("newest_fwd_e0", {30'd0, fwd_e0}, 2); chk("zero_fwd_e1", {30'd0, fwd_e1}, 0);
    flush();
    // $0 never stalls even right behind a long-latency writer
    setd(0, 1, 0, 3, 0, 2); cyc();
    setd(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("zero_no_stall", {31'd0, stall}, 0);
    flush();
    // reset while stalled clears the pipeline
    setd(0, 1, 0, 3, 8, 2); cyc();
    setd(8, 0, 8, 0, 9, 1);
    @(negedge clk); chk("pre_reset_stall", {31'd0, stall}, 1);
    reset = 1'b1;
    cyc(); reset = 1'b0;
    @(negedge clk); chk("post_reset_stall", {31'd0, stall}, 0); chk("post_reset_fwd_d0", {30'd0, fwd_d0}, 0);
    flush();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
